// File: rtl/sa_output_collector.sv
// sa_output_collector: de-skews the diagonally staggered column partial sums
// leaving the systolic array into aligned rows, requantizes each lane
// (round, arithmetic shift, optional ReLU, saturate) and writes one row per
// cycle to the output BRAM at a counted address, pulsing done_o after a burst.
module sa_output_collector #(
  parameter int NUM_COL    = 8,
  parameter int PSUM_WIDTH = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [10:0]                          burst_size_i,
  input  logic [4:0]                           shift_i,
  input  logic                                 relu_en_i,
  input  logic [NUM_COL-1:0]                   sa_valid_i,
  input  logic [NUM_COL-1:0][PSUM_WIDTH-1:0]   sa_psum_i,
  output logic                                 wr_en_o,
  output logic [9:0]                           wr_addr_o,
  output logic [NUM_COL-1:0][DATA_WIDTH-1:0]   wr_data_o,
  output logic                                 wr_last_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int EW = PSUM_WIDTH + 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = -SAT_MAX - EW'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                               state;
  logic [10:0]                          burst_cfg;
  logic [10:0]                          row_cnt;
  logic [4:0]                           shift_cfg;
  logic                                 relu_cfg;
  logic [NUM_COL-1:0]                   in_valid;
  logic                                 gate_err;
  logic [NUM_COL-1:0]                   al_valid;
  logic [NUM_COL-1:0][PSUM_WIDTH-1:0]   al_psum;
  logic                                 skew_err;
  logic                                 row_valid_a;
  logic [NUM_COL-1:0][PSUM_WIDTH-1:0]   psum_a;
  logic [NUM_COL-1:0][DATA_WIDTH-1:0]   requant;

  // Valids only enter the pipeline while collecting; anything else is an error.
  assign in_valid = (state == COLLECT) ? sa_valid_i : '0;
  assign gate_err = (state != COLLECT) && (|sa_valid_i);
  assign busy_o   = (state != IDLE);

  for (genvar j = 0; j < NUM_COL; j++) begin : g_lane
    localparam int D = NUM_COL - 1 - j;
    if (D == 0) begin : g_direct
      assign al_valid[j] = in_valid[j];
      assign al_psum[j]  = sa_psum_i[j];
    end else begin : g_delay
      logic [D-1:0]                 vsr;
      logic [D-1:0][PSUM_WIDTH-1:0] psr;
      // Delay early lanes so every lane of a row emerges in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          vsr <= '0;
          psr <= '0;
        end else begin
          vsr[0] <= in_valid[j];
          psr[0] <= sa_psum_i[j];
          for (int k = 1; k < D; k++) begin
            vsr[k] <= vsr[k-1];
            psr[k] <= psr[k-1];
          end
        end
      end
      assign al_valid[j] = vsr[D-1];
      assign al_psum[j]  = psr[D-1];
    end
  end

  // A partially valid aligned row means lanes slipped; that row is dropped.
  assign skew_err = (|al_valid) && !(&al_valid);

  // Stage A: register the aligned row, valid only when every lane agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_valid_a <= 1'b0;
      psum_a      <= '0;
    end else begin
      row_valid_a <= &al_valid;
      psum_a      <= al_psum;
    end
  end

  // Requantize each lane: round half up, arithmetic shift, ReLU, saturate.
  always_comb begin
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] v;
    requant = '0;
    for (int j = 0; j < NUM_COL; j++) begin
      ext = {psum_a[j][PSUM_WIDTH-1], psum_a[j]};
      rnd = '0;
      if (shift_cfg != 5'd0 && int'(shift_cfg) <= PSUM_WIDTH)
        rnd = EW'(1) << (shift_cfg - 5'd1);
      sum = ext + rnd;
      v   = sum >>> shift_cfg;
      if (relu_cfg && v[EW-1])
        v = '0;
      if (v > SAT_MAX)
        requant[j] = SAT_MAX[DATA_WIDTH-1:0];
      else if (v < SAT_MIN)
        requant[j] = SAT_MIN[DATA_WIDTH-1:0];
      else
        requant[j] = v[DATA_WIDTH-1:0];
    end
  end

  // Burst control FSM; stage B doubles as the registered BRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      burst_cfg <= '0;
      shift_cfg <= '0;
      relu_cfg  <= 1'b0;
      row_cnt   <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      wr_last_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      wr_en_o   <= 1'b0;
      wr_last_o <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            burst_cfg <= (burst_size_i > 11'd1024) ? 11'd1024 : burst_size_i;
            shift_cfg <= shift_i;
            relu_cfg  <= relu_en_i;
            row_cnt   <= '0;
            state     <= (burst_size_i == 11'd0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (row_valid_a) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= row_cnt[9:0];
            wr_data_o <= requant;
            row_cnt   <= row_cnt + 11'd1;
            if (row_cnt == burst_cfg - 11'd1) begin
              wr_last_o <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flag, cleared only when a new burst is accepted.
  always_ff @(posedge clk) begin
    if (rst)
      err_o <= 1'b0;
    else if (state == IDLE && start_i)
      err_o <= 1'b0;
    else if (skew_err || gate_err || (row_valid_a && state != COLLECT))
      err_o <= 1'b1;
  end

endmodule

// File: tb/tb_sa_output_collector.sv
// tb_sa_output_collector: directed bench for sa_output_collector. Rows are
// fed with the systolic-array diagonal skew; writes are logged by a monitor
// and compared against hand-computed rows.
module tb_sa_output_collector;

  localparam int NC = 8;
  localparam int PW = 24;
  localparam int DW = 8;
  localparam int LOGN = 2048;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_i;
  logic [10:0]              burst_size_i;
  logic [4:0]               shift_i;
  logic                     relu_en_i;
  logic [NC-1:0]            sa_valid_i;
  logic [NC-1:0][PW-1:0]    sa_psum_i;
  logic                     wr_en_o;
  logic [9:0]               wr_addr_o;
  logic [NC-1:0][DW-1:0]    wr_data_o;
  logic                     wr_last_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_count = 0;
  int done_cyc = 0;

  logic [9:0]  log_addr [0:LOGN-1];
  logic [63:0] log_data [0:LOGN-1];
  logic        log_last [0:LOGN-1];
  int          log_cyc  [0:LOGN-1];

  logic [PW-1:0] row_psum [0:1023][0:NC-1];
  logic [7:0]    exp_byte [0:NC-1];
  int            pv [NC];
  int            ev [NC];

  always #5 clk = ~clk;

  sa_output_collector #(.NUM_COL(NC), .PSUM_WIDTH(PW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .burst_size_i (burst_size_i),
    .shift_i      (shift_i),
    .relu_en_i    (relu_en_i),
    .sa_valid_i   (sa_valid_i),
    .sa_psum_i    (sa_psum_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_last_o    (wr_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // Log every write and done pulse shortly after the clock edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (wr_en_o && wr_count < LOGN) begin
      log_addr[wr_count] = wr_addr_o;
      log_data[wr_count] = wr_data_o;
      log_last[wr_count] = wr_last_o;
      log_cyc[wr_count]  = cyc;
      wr_count++;
    end
    if (done_o) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_row(input string tag, input int idx);
    for (int j = 0; j < NC; j++)
      check_output($sformatf("%s lane%0d", tag, j), 64'(log_data[idx][j*8 +: 8]), 64'(exp_byte[j]));
  endtask

  task automatic apply_stimulus(input int c, input int n, input int drop_row, input int drop_lane);
    int r;
    for (int j = 0; j < NC; j++) begin
      r = c - j;
      if (r >= 0 && r < n) begin
        sa_valid_i[j] = !(r == drop_row && j == drop_lane);
        sa_psum_i[j]  = row_psum[r][j];
      end else begin
        sa_valid_i[j] = 1'b0;
        sa_psum_i[j]  = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_burst(input int n, input int drop_row, input int drop_lane);
    for (int c = 0; c < n + NC - 1; c++)
      apply_stimulus(c, n, drop_row, drop_lane);
    sa_valid_i = '0;
    sa_psum_i  = '0;
  endtask

  task automatic start_burst(input int bsz, input int sh, input logic relu);
    burst_size_i = 11'(bsz);
    shift_i      = 5'(sh);
    relu_en_i    = relu;
    start_i      = 1'b1;
    @(negedge clk);
    start_i      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base_done, input int limit);
    for (int i = 0; i < limit && done_count == base_done; i++)
      @(negedge clk);
    check_output(tag, 64'(done_count), 64'(base_done + 1));
  endtask

  task automatic single_row(input string tag, input int sh, input logic relu);
    int bw;
    int bd;
    bw = wr_count;
    bd = done_count;
    for (int j = 0; j < NC; j++) begin
      row_psum[0][j] = PW'(pv[j]);
      exp_byte[j]    = 8'(ev[j]);
    end
    start_burst(1, sh, relu);
    drive_burst(1, -1, -1);
    wait_done({tag, " done"}, bd, 30);
    check_output({tag, " count"}, 64'(wr_count - bw), 64'(1));
    check_output({tag, " last"}, 64'(log_last[bw]), 64'(1));
    check_row(tag, bw);
  endtask

  initial begin
    int bw;
    int bd;
    int k;
    int bad_addr;
    int bad_gap;
    int bad_last;
    int bad_data;

    rst = 1'b1;
    start_i = 1'b0;
    burst_size_i = '0;
    shift_i = '0;
    relu_en_i = 1'b0;
    sa_valid_i = '0;
    sa_psum_i = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_output("rst wr_en", 64'(wr_en_o), 64'(0));
    check_output("rst wr_addr", 64'(wr_addr_o), 64'(0));
    check_output("rst wr_data", 64'(wr_data_o), 64'(0));
    check_output("rst wr_last", 64'(wr_last_o), 64'(0));
    check_output("rst busy", 64'(busy_o), 64'(0));
    check_output("rst done", 64'(done_o), 64'(0));
    check_output("rst err", 64'(err_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // T1: basic burst of four skewed rows
    $display("[TB] T1 basic burst");
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < NC; j++)
        row_psum[r][j] = PW'(r * 10 + j);
    bw = wr_count;
    bd = done_count;
    start_burst(4, 0, 1'b0);
    check_output("T1 busy", 64'(busy_o), 64'(1));
    k = cyc;
    drive_burst(4, -1, -1);
    wait_done("T1 done", bd, 40);
    check_output("T1 count", 64'(wr_count - bw), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("T1 addr%0d", i), 64'(log_addr[bw+i]), 64'(i));
      check_output($sformatf("T1 last%0d", i), 64'(log_last[bw+i]), 64'(i == 3));
      for (int j = 0; j < NC; j++)
        exp_byte[j] = 8'(i * 10 + j);
      check_row($sformatf("T1 row%0d", i), bw + i);
    end
    check_output("T1 latency", 64'(log_cyc[bw]), 64'(k + NC + 1));
    check_output("T1 done timing", 64'(done_cyc), 64'(log_cyc[bw+3] + 1));
    check_output("T1 err", 64'(err_o), 64'(0));
    @(negedge clk);
    check_output("T1 done pulse width", 64'(done_o), 64'(0));
    check_output("T1 idle busy", 64'(busy_o), 64'(0));

    // Zero-length burst goes straight to done with no writes
    bw = wr_count;
    bd = done_count;
    start_burst(0, 0, 1'b0);
    wait_done("B0 done", bd, 10);
    check_output("B0 no writes", 64'(wr_count - bw), 64'(0));

    // T2: requantization corner cases
    $display("[TB] T2 requant");
    pv = '{1000, 1020, -1000, -2000, 4, 3, -4, -5};
    ev = '{125, 127, -125, -128, 1, 0, 0, -1};
    single_row("T2 sh3", 3, 1'b0);
    ev = '{125, 127, 0, 0, 1, 0, 0, 0};
    single_row("T2 sh3 relu", 3, 1'b1);
    pv = '{5, -5, 7, 0, 255, 256, -3, 1};
    ev = '{3, -2, 4, 0, 127, 127, -1, 1};
    single_row("T2 sh1", 1, 1'b0);
    pv = '{-5000, 5000, 127, -128, 128, -129, 0, -1};
    ev = '{-128, 127, 127, -128, 127, -128, 0, -1};
    single_row("T2 sh0", 0, 1'b0);
    pv = '{-1, 5, -8388608, 8388607, 0, -100, 100, 1};
    ev = '{-1, 0, -1, 0, 0, -1, 0, 0};
    single_row("T2 sh30", 30, 1'b0);

    // T3: maximum burst, continuous rows
    $display("[TB] T3 burst 1024");
    for (int r = 0; r < 1024; r++)
      for (int j = 0; j < NC; j++)
        row_psum[r][j] = PW'((r % 64) + j);
    bw = wr_count;
    bd = done_count;
    start_burst(1024, 0, 1'b0);
    drive_burst(1024, -1, -1);
    wait_done("T3 done", bd, 100);
    repeat (20) @(negedge clk);
    check_output("T3 count", 64'(wr_count - bw), 64'(1024));
    bad_addr = 0;
    bad_gap = 0;
    bad_last = 0;
    bad_data = 0;
    for (int i = 0; i < 1024; i++) begin
      if (log_addr[bw+i] !== 10'(i)) bad_addr++;
      if (i > 0 && log_cyc[bw+i] != log_cyc[bw+i-1] + 1) bad_gap++;
      if (log_last[bw+i] !== (i == 1023)) bad_last++;
      for (int j = 0; j < NC; j++)
        if (log_data[bw+i][j*8 +: 8] !== 8'((i % 64) + j)) bad_data++;
    end
    check_output("T3 addr errors", 64'(bad_addr), 64'(0));
    check_output("T3 gaps", 64'(bad_gap), 64'(0));
    check_output("T3 last errors", 64'(bad_last), 64'(0));
    check_output("T3 data errors", 64'(bad_data), 64'(0));
    check_output("T3 single done", 64'(done_count - bd), 64'(1));
    check_output("T3 err", 64'(err_o), 64'(0));
    check_output("T3 busy", 64'(busy_o), 64'(0));

    // T4: lane 3 drops its valid for row 1
    $display("[TB] T4 lane misalignment");
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < NC; j++)
        row_psum[r][j] = PW'(50 + r * 8 + j);
    bw = wr_count;
    bd = done_count;
    start_burst(3, 0, 1'b0);
    drive_burst(4, 1, 3);
    wait_done("T4 done", bd, 40);
    check_output("T4 count", 64'(wr_count - bw), 64'(3));
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("T4 addr%0d", i), 64'(log_addr[bw+i]), 64'(i));
      for (int j = 0; j < NC; j++)
        exp_byte[j] = 8'(50 + (i == 0 ? 0 : i + 1) * 8 + j);
      check_row($sformatf("T4 row%0d", i), bw + i);
    end
    check_output("T4 last", 64'(log_last[bw+2]), 64'(1));
    repeat (5) @(negedge clk);
    check_output("T4 err sticky", 64'(err_o), 64'(1));

    // T6: reset in the middle of a burst
    $display("[TB] T6 reset mid-burst");
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < NC; j++)
        row_psum[r][j] = PW'(r + j);
    bw = wr_count;
    bd = done_count;
    start_burst(32, 0, 1'b0);
    for (int c = 0; c < 16 + NC - 1; c++) begin
      apply_stimulus(c, 16, -1, -1);
      if (wr_count - bw >= 10) break;
    end
    rst = 1'b1;
    sa_valid_i = '0;
    sa_psum_i = '0;
    @(negedge clk);
    check_output("T6 wr_en", 64'(wr_en_o), 64'(0));
    check_output("T6 wr_addr", 64'(wr_addr_o), 64'(0));
    check_output("T6 wr_data", 64'(wr_data_o), 64'(0));
    check_output("T6 wr_last", 64'(wr_last_o), 64'(0));
    check_output("T6 busy", 64'(busy_o), 64'(0));
    check_output("T6 err", 64'(err_o), 64'(0));
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_output("T6 writes before reset", 64'(wr_count - bw), 64'(10));
    check_output("T6 no done", 64'(done_count - bd), 64'(0));
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < NC; j++)
        row_psum[r][j] = PW'(7 * r + j + 1);
    bw = wr_count;
    bd = done_count;
    start_burst(2, 0, 1'b0);
    drive_burst(2, -1, -1);
    wait_done("T6 done", bd, 40);
    check_output("T6 count", 64'(wr_count - bw), 64'(2));
    check_output("T6 addr0", 64'(log_addr[bw]), 64'(0));
    check_output("T6 addr1", 64'(log_addr[bw+1]), 64'(1));
    check_output("T6 last", 64'(log_last[bw+1]), 64'(1));
    for (int j = 0; j < NC; j++)
      exp_byte[j] = 8'(7 + j + 1);
    check_row("T6 row1", bw + 1);

    // T5: valids while idle set the error; a new start clears it
    $display("[TB] T5 idle valids");
    check_output("T5 err before", 64'(err_o), 64'(0));
    bw = wr_count;
    sa_valid_i = 8'h01;
    @(negedge clk);
    sa_valid_i = 8'hff;
    @(negedge clk);
    sa_valid_i = '0;
    repeat (12) @(negedge clk);
    check_output("T5 no writes", 64'(wr_count - bw), 64'(0));
    check_output("T5 err set", 64'(err_o), 64'(1));
    check_output("T5 idle busy", 64'(busy_o), 64'(0));
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < NC; j++)
        row_psum[r][j] = PW'(20 + r * 5 + j);
    bd = done_count;
    start_burst(2, 0, 1'b0);
    check_output("T5 err cleared", 64'(err_o), 64'(0));
    check_output("T5 busy", 64'(busy_o), 64'(1));
    drive_burst(2, -1, -1);
    wait_done("T5 done", bd, 40);
    check_output("T5 count", 64'(wr_count - bw), 64'(2));
    check_output("T5 addr0", 64'(log_addr[bw]), 64'(0));
    check_output("T5 addr1", 64'(log_addr[bw+1]), 64'(1));
    for (int j = 0; j < NC; j++)
      exp_byte[j] = 8'(20 + j);
    check_row("T5 row0", bw);
    for (int j = 0; j < NC; j++)
      exp_byte[j] = 8'(25 + j);
    check_row("T5 row1", bw + 1);
    check_output("T5 err final", 64'(err_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
